// File: rtl/vga_pkg.sv
// Shared VGA definitions: the 640x480@60 timing set, the 12-bit colour type
// and the frame-total helper used to size the raster counters.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-rate enable divider plus h/v raster counters; all decodes are taken
// from the pre-increment counters so the top can register them on the tick.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CLK_DIV  = 2,
  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          o_tick,
  output logic [XW-1:0] o_h,
  output logic [YW-1:0] o_v,
  output logic          o_hsync_act,
  output logic          o_vsync_act,
  output logic          o_active,
  output logic          o_frame_tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("vga_timing_gen: timing parameters and CLK_DIV must all be >= 1");
  end

  logic [DW-1:0] r_div;
  logic [XW-1:0] r_h;
  logic [YW-1:0] r_v;
  logic          w_tick;

  assign w_tick = (r_div == DW'(CLK_DIV - 1));

  // The divider restarts at 0, so the first tick lands on the CLK_DIV-th clock out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        if (r_h == XW'(H_TOTAL - 1)) begin
          r_h <= '0;
          r_v <= (r_v == YW'(V_TOTAL - 1)) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  assign o_tick       = w_tick;
  assign o_h          = r_h;
  assign o_v          = r_v;
  assign o_hsync_act  = (r_h >= XW'(H_ACTIVE + H_FP)) && (r_h < XW'(H_ACTIVE + H_FP + H_SYNC));
  assign o_vsync_act  = (r_v >= YW'(V_ACTIVE + V_FP)) && (r_v < YW'(V_ACTIVE + V_FP + V_SYNC));
  assign o_active     = (r_h < XW'(H_ACTIVE)) && (r_v < YW'(V_ACTIVE));
  assign o_frame_tick = w_tick && (r_h == XW'(H_TOTAL - 1)) && (r_v == YW'(V_ACTIVE - 1));

endmodule

// File: rtl/vga_sprite_engine.sv
// VGA raster generator with an N-sprite solid-square overlay; sprite state is
// shadowed at the start of vertical blanking so a frame never tears.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_FP        = VGA_H_FP,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BP        = VGA_H_BP,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_FP        = VGA_V_FP,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BP        = VGA_V_BP,
  parameter bit SYNC_POL    = 1'b0,
  parameter int CLK_DIV     = 2,
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_SIZE = 8,
  localparam int H_TOTAL    = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL    = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW         = $clog2(H_TOTAL),
  localparam int YW         = $clog2(V_TOTAL)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SPRITES*XW-1:0] sprite_x,
  input  logic [NUM_SPRITES*YW-1:0] sprite_y,
  input  logic [NUM_SPRITES*12-1:0] sprite_color,
  input  logic [NUM_SPRITES-1:0]    sprite_en,
  input  logic [11:0]               bg_color,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic [3:0]                o_red,
  output logic [3:0]                o_green,
  output logic [3:0]                o_blue,
  output logic                      o_active,
  output logic [XW-1:0]             o_pix_x,
  output logic [YW-1:0]             o_pix_y,
  output logic                      o_frame_start
);

  if (NUM_SPRITES < 1 || NUM_SPRITES > 8 || SPRITE_SIZE < 1) begin : g_bad_sprites
    $error("vga_sprite_engine: NUM_SPRITES must be 1..8 and SPRITE_SIZE >= 1");
  end

  logic                      w_tick;
  logic [XW-1:0]             w_h;
  logic [YW-1:0]             w_v;
  logic                      w_hsync_act;
  logic                      w_vsync_act;
  logic                      w_active;
  logic                      w_frame_tick;
  logic [NUM_SPRITES-1:0]    w_hit;
  rgb444_t                   w_pix;

  logic [NUM_SPRITES*XW-1:0] r_x_s;
  logic [NUM_SPRITES*YW-1:0] r_y_s;
  logic [NUM_SPRITES*12-1:0] r_color_s;
  logic [NUM_SPRITES-1:0]    r_en_s;
  logic                      r_hsync;
  logic                      r_vsync;
  rgb444_t                   r_rgb;
  logic                      r_active;
  logic [XW-1:0]             r_pix_x;
  logic [YW-1:0]             r_pix_y;
  logic                      r_frame_start;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clock        (clock),
    .reset        (reset),
    .o_tick       (w_tick),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_hsync_act  (w_hsync_act),
    .o_vsync_act  (w_vsync_act),
    .o_active     (w_active),
    .o_frame_tick (w_frame_tick)
  );

  // Upper bounds are formed one bit wider so a sprite near the edge cannot wrap.
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
    logic [XW-1:0] w_sx;
    logic [YW-1:0] w_sy;
    assign w_sx     = r_x_s[i*XW +: XW];
    assign w_sy     = r_y_s[i*YW +: YW];
    assign w_hit[i] = r_en_s[i] &&
                      (w_h >= w_sx) && ({1'b0, w_h} < {1'b0, w_sx} + (XW+1)'(SPRITE_SIZE)) &&
                      (w_v >= w_sy) && ({1'b0, w_v} < {1'b0, w_sy} + (YW+1)'(SPRITE_SIZE));
  end

  always_comb begin
    w_pix = rgb444_t'(bg_color);
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_pix = rgb444_t'(r_color_s[i*12 +: 12]);
    end
  end

  // The frame-start pulse is cleared on the following clock so it stays one clock wide.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_x_s         <= '0;
      r_y_s         <= '0;
      r_color_s     <= '0;
      r_en_s        <= '0;
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_rgb         <= '0;
      r_active      <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_tick;
      if (w_tick) begin
        r_hsync  <= w_hsync_act ? SYNC_POL : ~SYNC_POL;
        r_vsync  <= w_vsync_act ? SYNC_POL : ~SYNC_POL;
        r_active <= w_active;
        r_pix_x  <= w_h;
        r_pix_y  <= w_v;
        r_rgb    <= w_active ? w_pix : '0;
        if (w_frame_tick) begin
          r_x_s     <= sprite_x;
          r_y_s     <= sprite_y;
          r_color_s <= sprite_color;
          r_en_s    <= sprite_en;
        end
      end
    end
  end

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_red         = r_rgb.r;
  assign o_green       = r_rgb.g;
  assign o_blue        = r_rgb.b;
  assign o_active      = r_active;
  assign o_pix_x       = r_pix_x;
  assign o_pix_y       = r_pix_y;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Bench for vga_sprite_engine on a shrunken raster: a tick-count reference
// model checks every clock, plus table-driven probes and directed sequences.
module tb_vga_sprite_engine;

  localparam int HA = 24, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 16, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int CD = 2, NS = 4, SS = 4;
  localparam int XW = $clog2(HT);
  localparam int YW = $clog2(VT);
  localparam int FRAME_CLKS = HT * VT * CD;

  typedef struct {
    int x0; int y0; logic [11:0] c0; bit en0;
    int x1; int y1; logic [11:0] c1; bit en1;
    int x3; int y3; logic [11:0] c3; bit en3;
    logic [11:0] bg;
    int px; int py;
    logic [11:0] expRgb;
  } Vec_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [NS*XW-1:0]     sprite_x = '0;
  logic [NS*YW-1:0]     sprite_y = '0;
  logic [NS*12-1:0]     sprite_color = '0;
  logic [NS-1:0]        sprite_en = '0;
  logic [11:0]          bg_color = '0;
  logic                 o_hsync, o_vsync, o_active, o_frame_start;
  logic [3:0]           o_red, o_green, o_blue;
  logic [XW-1:0]        o_pix_x;
  logic [YW-1:0]        o_pix_y;

  int nVec = 0;
  int nMis = 0;
  bit chkEn = 1'b0;

  always #5 clock = ~clock;

  vga_sprite_engine #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .CLK_DIV(CD), .NUM_SPRITES(NS), .SPRITE_SIZE(SS)
  ) dut (
    .clock(clock), .reset(reset),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_color(sprite_color),
    .sprite_en(sprite_en), .bg_color(bg_color),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_active(o_active), .o_pix_x(o_pix_x), .o_pix_y(o_pix_y),
    .o_frame_start(o_frame_start)
  );

  // Reference model: the raster position is derived from the number of ticks
  // since reset, and sprites are drawn from a frame-latched copy of the inputs.
  int          clkCnt = 0;
  int          mp, mh, mv;
  int          mx[NS], my[NS];
  logic [11:0] mc[NS];
  bit          men[NS];
  bit          eHs = 1, eVs = 1, eAct = 0, eFs = 0;
  int          eX = 0, eY = 0;
  logic [11:0] eRgb = '0;

  function automatic logic [11:0] refColour(int h, int v);
    for (int i = 0; i < NS; i++) begin
      if (men[i] && h >= mx[i] && h < mx[i] + SS && v >= my[i] && v < my[i] + SS)
        return mc[i];
    end
    return bg_color;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      clkCnt = 0;
      eHs = 1; eVs = 1; eAct = 0; eFs = 0; eX = 0; eY = 0; eRgb = '0;
      for (int i = 0; i < NS; i++) begin
        mx[i] = 0; my[i] = 0; mc[i] = '0; men[i] = 0;
      end
    end else begin
      clkCnt = clkCnt + 1;
      eFs = 0;
      if (clkCnt % CD == 0) begin
        mp   = clkCnt / CD - 1;
        mh   = mp % HT;
        mv   = (mp / HT) % VT;
        eAct = (mh < HA) && (mv < VA);
        eHs  = !(mh >= HA + HFP && mh < HA + HFP + HS);
        eVs  = !(mv >= VA + VFP && mv < VA + VFP + VS);
        eX   = mh;
        eY   = mv;
        eRgb = eAct ? refColour(mh, mv) : 12'h000;
        if (mh == HT - 1 && mv == VA - 1) begin
          eFs = 1;
          for (int i = 0; i < NS; i++) begin
            mx[i]  = int'(sprite_x[i*XW +: XW]);
            my[i]  = int'(sprite_y[i*YW +: YW]);
            mc[i]  = sprite_color[i*12 +: 12];
            men[i] = sprite_en[i];
          end
        end
      end
    end
  end

  // Every clock, all outputs are compared against the model as one bundle.
  always @(negedge clock) begin
    if (chkEn) begin
      nVec++;
      if ({o_hsync, o_vsync, o_active, o_frame_start} !== {eHs, eVs, eAct, eFs} ||
          o_pix_x !== XW'(eX) || o_pix_y !== YW'(eY) || {o_red, o_green, o_blue} !== eRgb) begin
        nMis++;
        $display("[TB] FAIL monitor t=%0t got hs=%b vs=%b act=%b fs=%b x=%0d y=%0d rgb=%h, expected hs=%b vs=%b act=%b fs=%b x=%0d y=%0d rgb=%h",
                 $time, o_hsync, o_vsync, o_active, o_frame_start, o_pix_x, o_pix_y,
                 {o_red, o_green, o_blue}, eHs, eVs, eAct, eFs, eX, eY, eRgb);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    nVec++;
    if (got !== expv) begin
      nMis++;
      $display("[TB] FAIL %s got %h expected %h", name, got, expv);
    end
  endtask

  task automatic applyStimulus(input Vec_t v);
    sprite_x     = '0;
    sprite_y     = '0;
    sprite_color = '0;
    sprite_x[0*XW +: XW]     = XW'(v.x0);
    sprite_y[0*YW +: YW]     = YW'(v.y0);
    sprite_color[0*12 +: 12] = v.c0;
    sprite_x[1*XW +: XW]     = XW'(v.x1);
    sprite_y[1*YW +: YW]     = YW'(v.y1);
    sprite_color[1*12 +: 12] = v.c1;
    sprite_x[3*XW +: XW]     = XW'(v.x3);
    sprite_y[3*YW +: YW]     = YW'(v.y3);
    sprite_color[3*12 +: 12] = v.c3;
    sprite_en    = {v.en3, 1'b0, v.en1, v.en0};
    bg_color     = v.bg;
  endtask

  task automatic waitFrameStart(input string name);
    bit ok = 0;
    for (int n = 0; n < 2 * FRAME_CLKS && !ok; n++) begin
      @(negedge clock);
      if (o_frame_start === 1'b1) ok = 1;
    end
    if (!ok) checkOutput({name, "_frame_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic probePixel(input string name, input int px, input int py, input logic [11:0] expRgb);
    bit ok = 0;
    for (int n = 0; n < FRAME_CLKS + 8 && !ok; n++) begin
      @(negedge clock);
      if (o_pix_x === XW'(px) && o_pix_y === YW'(py)) ok = 1;
    end
    if (!ok) checkOutput({name, "_pixel_timeout"}, 32'd0, 32'd1);
    else checkOutput(name, {20'd0, o_red, o_green, o_blue}, {20'd0, expRgb});
  endtask

  Vec_t vecs[14];

  initial begin
    vecs[0]  = '{5, 3, 12'hF00, 1,  0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h00F,  5, 3, 12'hF00};
    vecs[1]  = '{5, 3, 12'hF00, 1,  0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h00F,  8, 6, 12'hF00};
    vecs[2]  = '{5, 3, 12'hF00, 1,  0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h00F,  9, 3, 12'h00F};
    vecs[3]  = '{5, 3, 12'hF00, 1,  0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h00F,  5, 7, 12'h00F};
    vecs[4]  = '{2, 2, 12'h0F0, 1,  4, 4, 12'h00F, 1,  0, 0, 12'h000, 0,  12'h123,  4, 4, 12'h0F0};
    vecs[5]  = '{2, 2, 12'h0F0, 1,  4, 4, 12'h00F, 1,  0, 0, 12'h000, 0,  12'h123,  7, 7, 12'h00F};
    vecs[6]  = '{2, 2, 12'h0F0, 0,  4, 4, 12'h00F, 1,  0, 0, 12'h000, 0,  12'h123,  4, 4, 12'h00F};
    vecs[7]  = '{22, 5, 12'hF0F, 1, 0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h123, 23, 5, 12'hF0F};
    vecs[8]  = '{22, 5, 12'hF0F, 1, 0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h123, 24, 5, 12'h000};
    vecs[9]  = '{22, 5, 12'hF0F, 1, 0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h123,  0, 6, 12'h123};
    vecs[10] = '{3, 14, 12'h0FF, 1, 0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h123,  3, 15, 12'h0FF};
    vecs[11] = '{3, 14, 12'h0FF, 1, 0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  12'h123,  3, 0, 12'h123};
    vecs[12] = '{0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  10, 10, 12'hABC, 1, 12'h456, 10, 10, 12'hABC};
    vecs[13] = '{0, 0, 12'h000, 0,  0, 0, 12'h000, 0,  10, 10, 12'hABC, 1, 12'h456, 14, 10, 12'h456};

    // Reset state
    repeat (3) @(negedge clock);
    chkEn = 1'b1;
    checkOutput("reset_rgb", {20'd0, o_red, o_green, o_blue}, 32'd0);
    checkOutput("reset_sync", {30'd0, o_hsync, o_vsync}, 32'd3);
    checkOutput("reset_pos", {22'd0, o_active, o_pix_x, o_pix_y}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("first_pixel", {22'd0, o_active, o_pix_x, o_pix_y}, {22'd0, 1'b1, 10'd0});

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      waitFrameStart($sformatf("vec%0d", i));
      probePixel($sformatf("vec%0d", i), vecs[i].px, vecs[i].py, vecs[i].expRgb);
    end

    // Moving a sprite mid-frame only takes effect after the next capture.
    applyStimulus('{5, 3, 12'hF00, 1, 0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 12'h00F, 0, 0, 12'h000});
    waitFrameStart("shadow");
    probePixel("shadow_pre_row1", 0, 1, 12'h00F);
    sprite_x[0 +: XW] = XW'(12);
    probePixel("shadow_old_pos", 5, 3, 12'hF00);
    probePixel("shadow_new_pos_early", 12, 3, 12'h00F);
    waitFrameStart("shadow2");
    probePixel("shadow_old_pos_cleared", 5, 3, 12'h00F);
    probePixel("shadow_new_pos", 12, 3, 12'hF00);

    // Reset partway through a line restarts the raster and clears the shadows.
    probePixel("pre_reset", 10, 2, 12'h00F);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("midreset_rgb", {20'd0, o_red, o_green, o_blue}, 32'd0);
    checkOutput("midreset_sync", {30'd0, o_hsync, o_vsync}, 32'd3);
    checkOutput("midreset_pos", {22'd0, o_active, o_pix_x, o_pix_y}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midreset_hold", {22'd0, o_active, o_pix_x, o_pix_y}, 32'd0);
    @(negedge clock);
    checkOutput("midreset_restart", {22'd0, o_active, o_pix_x, o_pix_y}, {22'd0, 1'b1, 10'd0});
    checkOutput("midreset_no_sprite", {20'd0, o_red, o_green, o_blue}, 32'h00F);

    // Random sprite traffic and occasional resets against the model.
    for (int n = 0; n < 6 * FRAME_CLKS; n++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 2999) == 0);
      if ($urandom_range(0, 99) == 0) begin
        for (int i = 0; i < NS; i++) begin
          sprite_x[i*XW +: XW]     = XW'($urandom_range(0, HT - 1));
          sprite_y[i*YW +: YW]     = YW'($urandom_range(0, VT - 1));
          sprite_color[i*12 +: 12] = 12'($urandom);
        end
        sprite_en = NS'($urandom);
        bg_color  = 12'($urandom);
      end
    end
    reset = 1'b0;
    @(negedge clock);
    chkEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
